st_field_rmw: RTL and testbench
===============================

// Module: st_field_rmw
// PURPOSE
//  Parametrised field-store unit for the MIX datapath: performs a complete STx read-modify-write.
//  Latches a register value, address and field spec (L:R). Reads the memory word, replaces field
//  L:R with the rightmost bytes of the register, then writes the word back.
//  Full-word fields skip the read. Illegal fields are rejected with no memory traffic.
//  Sits between the instruction sequencer (start/stop) and the memory port arbiter.
// PARAMETERS
//  BYTE_W   6   bits per byte
//  NBYTES   5   bytes per word; word width W = 1 + NBYTES*BYTE_W (bit W-1 = sign)
//  ADDR_W   12  memory address width
//  FIELD_W  6   field-spec width; spec = 8*L + R
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-high
//  start        in   1        one-cycle request; accepted only while busy=0
//  field        in   FIELD_W  field spec 8L+R, sampled with start
//  addr         in   ADDR_W   target address, sampled with start
//  in           in   W        register value, sampled with start
//  busy         out  1        operation in progress
//  stop         out  1        one-cycle completion pulse
//  err          out  1        with stop: field was illegal, nothing written
//  mem_addr     out  ADDR_W   latched address, valid while mem_rd_req or mem_wr_req is high
//  mem_rd_req   out  1        read request, held until mem_rd_valid
//  mem_rd_data  in   W        read data, sampled when mem_rd_valid=1
//  mem_rd_valid in   1        read data valid
//  mem_wr_req   out  1        write request, held until mem_wr_ack
//  mem_wr_data  out  W        merged word, stable while mem_wr_req=1
//  mem_wr_ack   in   1        write accepted
// BEHAVIOUR
//  Reset (async): state=IDLE. busy, stop, err, mem_rd_req and mem_wr_req are 0.
//   mem_addr and mem_wr_data are 0. Reset mid-operation drops requests at once; no partial write.
//  Byte numbering: byte k (1..NBYTES) occupies bits [(NBYTES-k)*BYTE_W +: BYTE_W]; byte 1 is most significant.
//  Legal field: L <= R <= NBYTES. Anything else is illegal.
//  Merge rule:
//   - L=0: sign := in[W-1].
//   - Bytes max(L,1)..R := the rightmost R-max(L,1)+1 bytes of in.
//   - All other bits keep the memory value.
//  FSM:
//   IDLE  - start: latch field, addr, in; busy=1.
//           illegal field -> DONE with err.
//           field = 0:NBYTES -> WRITE, mem_wr_data=in.
//           otherwise -> READ.
//   READ  - mem_rd_req=1. On mem_rd_valid, register merge(mem_rd_data) into mem_wr_data; -> WRITE.
//   WRITE - mem_wr_req=1. On mem_wr_ack -> DONE.
//   DONE  - stop=1 for exactly one cycle, err as decided; busy=0 next cycle -> IDLE.
//  Latency from start to stop, zero-wait memory:
//   - partial field: 3 cycles.
//   - full field: 2 cycles.
//   - illegal field: 1 cycle.
//   Each memory wait cycle adds one.
//  start while busy=1 is ignored, including the DONE cycle.
//  mem_rd_valid outside READ and mem_wr_ack outside WRITE are ignored.
//  A valid/ack in the same cycle the request rises counts as accepted.
//  R=0 with L=0 (spec 0) is legal: sign only.
// STRUCTURE
//  Shared package mix_pkg:
//   - BYTE_W, NBYTES, W defaults.
//   - field_l()/field_r() decode functions.
//   - FSM state typedef {IDLE, READ, WRITE, DONE}.
//  Sub-module st_field_merge: purely combinational, inputs (mem, in, L, R), output merged word.
//   Generate loop over bytes. Reused by a later load/compare unit.
// TESTING (BYTE_W=6, NBYTES=5)
//  Common setup: mem = +|1|2|3|4|5, in = -|6|7|8|9|0, zero-wait memory.
//  1. field 19 (2:3) -> mem_wr_data = +|1|9|0|4|5; stop 3 cycles after start; err=0.
//  2. field 1 (0:1) -> -|0|2|3|4|5. field 45 (5:5) -> +|1|2|3|4|0.
//  3. field 5 (0:5) -> no mem_rd_req; write -|6|7|8|9|0; stop after 2 cycles.
//  4. field 26 (3:2) or 6 (0:6) -> stop+err 1 cycle after start; no rd/wr request.
//  5. mem_rd_valid delayed 4 cycles, mem_wr_ack delayed 2 -> requests held stable;
//     start pulses while busy are ignored; a single stop.
//  6. rst asserted while in WRITE -> mem_wr_req and busy fall asynchronously;
//     next start after release proceeds normally.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared MIX datapath definitions: word geometry defaults, field-spec decode
// helpers and the store-unit state encoding.
package mix_pkg;

   localparam int DEF_BYTE_W  = 6;
   localparam int DEF_NBYTES  = 5;
   localparam int DEF_W       = 1 + DEF_NBYTES * DEF_BYTE_W;
   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_FIELD_W = 6;

   // Field spec is 8*L + R: R lives in the low three bits, L above it.
   localparam int DEF_R_W = 3;
   localparam int DEF_L_W = DEF_FIELD_W - DEF_R_W;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_e;

   function automatic logic [DEF_L_W-1:0] field_l(input logic [DEF_FIELD_W-1:0] f);
      return f[DEF_FIELD_W-1:DEF_R_W];
   endfunction

   function automatic logic [DEF_R_W-1:0] field_r(input logic [DEF_FIELD_W-1:0] f);
      return f[DEF_R_W-1:0];
   endfunction

endpackage

// File: rtl/st_field_merge.sv
// Combinational field merge: bytes max(L,1)..R take the rightmost bytes of the
// register value, sign is replaced when L=0, everything else keeps memory.
module st_field_merge
   import mix_pkg::*;
#(
   parameter int BYTE_W = DEF_BYTE_W,
   parameter int NBYTES = DEF_NBYTES,
   parameter int L_W    = DEF_L_W,
   parameter int R_W    = DEF_R_W,
   localparam int W     = 1 + NBYTES * BYTE_W
) (
   input  logic [W-1:0]   mem,
   input  logic [W-1:0]   in,
   input  logic [L_W-1:0] l,
   input  logic [R_W-1:0] r,
   output logic [W-1:0]   merged
);

   int           lo;
   int           shamt;
   logic [W-2:0] in_sh;

   // Shifting the magnitude left by (NBYTES-R) bytes lines the rightmost
   // bytes of the register up under target bytes ..R.
   always_comb begin
      lo    = (l == '0) ? 1 : int'(l);
      shamt = (int'(r) > NBYTES) ? 0 : (NBYTES - int'(r)) * BYTE_W;
      in_sh = in[W-2:0] << shamt;
   end

   assign merged[W-1] = (l == '0) ? in[W-1] : mem[W-1];

   for (genvar k = 1; k <= NBYTES; k++) begin : g_byte
      localparam int LSB = (NBYTES - k) * BYTE_W;
      logic sel;
      assign sel = (k >= lo) && (k <= int'(r));
      assign merged[LSB +: BYTE_W] = sel ? in_sh[LSB +: BYTE_W] : mem[LSB +: BYTE_W];
   end

endmodule

// File: rtl/st_field_rmw.sv
// STx read-modify-write sequencer: latches the request, reads the target word,
// merges the field and writes it back; full-word stores skip the read.
module st_field_rmw
   import mix_pkg::*;
#(
   parameter int BYTE_W  = DEF_BYTE_W,
   parameter int NBYTES  = DEF_NBYTES,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int FIELD_W = DEF_FIELD_W,
   localparam int W      = 1 + NBYTES * BYTE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FIELD_W-1:0] field,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [W-1:0]       in,
   output logic               busy,
   output logic               stop,
   output logic               err,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd_req,
   input  logic [W-1:0]       mem_rd_data,
   input  logic               mem_rd_valid,
   output logic               mem_wr_req,
   output logic [W-1:0]       mem_wr_data,
   input  logic               mem_wr_ack
);

   state_e             state_q, state_d;
   logic [FIELD_W-1:0] field_q, field_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [W-1:0]       in_q, in_d;
   logic [W-1:0]       wr_data_q, wr_data_d;
   logic               err_q, err_d;

   logic [DEF_L_W-1:0] l_new, l_q;
   logic [DEF_R_W-1:0] r_new, r_q;
   logic               legal_new;
   logic               full_new;
   logic [W-1:0]       merged;

   // Incoming spec is classified at start; the latched spec drives the merge.
   always_comb begin
      l_new     = field_l(field);
      r_new     = field_r(field);
      l_q       = field_l(field_q);
      r_q       = field_r(field_q);
      legal_new = (l_new <= r_new) && (int'(r_new) <= NBYTES);
      full_new  = (l_new == '0) && (int'(r_new) == NBYTES);
   end

   st_field_merge #(
      .BYTE_W (BYTE_W),
      .NBYTES (NBYTES),
      .L_W    (DEF_L_W),
      .R_W    (DEF_R_W)
   ) u_merge (
      .mem    (mem_rd_data),
      .in     (in_q),
      .l      (l_q),
      .r      (r_q),
      .merged (merged)
   );

   // NOTE: every signal written here gets a default first, so no path leaves a latch.
   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      addr_d    = addr_q;
      in_d      = in_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               field_d = field;
               addr_d  = addr;
               in_d    = in;
               err_d   = !legal_new;
               if (!legal_new) begin
                  state_d = DONE;
               end else if (full_new) begin
                  wr_data_d = in;
                  state_d   = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (mem_rd_valid) begin
               wr_data_d = merged;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            if (mem_wr_ack) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking updates so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         field_q   <= '0;
         addr_q    <= '0;
         in_q      <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         addr_q    <= addr_d;
         in_q      <= in_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   // Handshake outputs decode straight from the state flop so reset drops them at once.
   assign busy        = (state_q != IDLE);
   assign stop        = (state_q == DONE);
   assign err         = (state_q == DONE) && err_q;
   assign mem_rd_req  = (state_q == READ);
   assign mem_wr_req  = (state_q == WRITE);
   assign mem_addr    = addr_q;
   assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_st_field_rmw.sv
// Directed bench for st_field_rmw with a memory responder of programmable
// read/write wait states.
module tb_st_field_rmw;

   localparam int BYTE_W  = 6;
   localparam int NBYTES  = 5;
   localparam int ADDR_W  = 12;
   localparam int FIELD_W = 6;
   localparam int W       = 1 + NBYTES * BYTE_W;

   logic               clk;
   logic               rst;
   logic               start;
   logic [FIELD_W-1:0] field;
   logic [ADDR_W-1:0]  addr;
   logic [W-1:0]       in_v;
   logic               busy;
   logic               stop;
   logic               err;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rd_req;
   logic [W-1:0]       mem_rd_data;
   logic               mem_rd_valid;
   logic               mem_wr_req;
   logic [W-1:0]       mem_wr_data;
   logic               mem_wr_ack;

   int n_cmp = 0;
   int n_bad = 0;

   int rd_delay = 0;
   int wr_delay = 0;
   int rd_wait;
   int wr_wait;

   int                wr_cnt = 0;
   logic [W-1:0]      wr_last = '0;
   logic [ADDR_W-1:0] wr_addr_last = '0;

   st_field_rmw #(
      .BYTE_W  (BYTE_W),
      .NBYTES  (NBYTES),
      .ADDR_W  (ADDR_W),
      .FIELD_W (FIELD_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .field        (field),
      .addr         (addr),
      .in           (in_v),
      .busy         (busy),
      .stop         (stop),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_data  (mem_rd_data),
      .mem_rd_valid (mem_rd_valid),
      .mem_wr_req   (mem_wr_req),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_ack   (mem_wr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: answers after rd_delay / wr_delay wait cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_wait <= 0;
         wr_wait <= 0;
      end else begin
         rd_wait <= mem_rd_req ? rd_wait + 1 : 0;
         wr_wait <= mem_wr_req ? wr_wait + 1 : 0;
      end
   end

   assign mem_rd_valid = mem_rd_req && (rd_wait >= rd_delay);
   assign mem_wr_ack   = mem_wr_req && (wr_wait >= wr_delay);

   always @(posedge clk) begin
      if (mem_wr_req && mem_wr_ack) begin
         wr_cnt       <= wr_cnt + 1;
         wr_last      <= mem_wr_data;
         wr_addr_last <= mem_addr;
      end
   end

   function automatic logic [W-1:0] word(input logic s, input int b1, input int b2,
                                         input int b3, input int b4, input int b5);
      return {s, 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
   endfunction

   logic [W-1:0] mem_word;
   logic [W-1:0] reg_word;

   // Issues one request and follows it to stop plus two idle cycles.
   // With hammer=1 an illegal start is pulsed on every busy cycle.
   task automatic do_op(input logic [FIELD_W-1:0] f, input logic [ADDR_W-1:0] a,
                        input logic [W-1:0] v, input logic hammer,
                        output int lat, output int rd_n, output int wr_n,
                        output int stops, output logic e);
      @(negedge clk);
      field = f;
      addr  = a;
      in_v  = v;
      start = 1'b1;
      lat   = 0;
      rd_n  = 0;
      wr_n  = 0;
      stops = 0;
      e     = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         start = hammer;
         if (hammer) begin
            field = 6'd6;
            addr  = 12'hABC;
            in_v  = '0;
         end
         rd_n += int'(mem_rd_req);
         wr_n += int'(mem_wr_req);
         if (stop) begin
            stops++;
            e = err;
         end
      end while (!stop && lat < 40);
      repeat (2) begin
         @(negedge clk);
         start = 1'b0;
         rd_n  += int'(mem_rd_req);
         wr_n  += int'(mem_wr_req);
         stops += int'(stop);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (stop !== 1'b0) begin n_bad++; $display("FAIL rst_stop: got %b want 0", stop); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
      n_cmp++; if (mem_rd_req !== 1'b0) begin n_bad++; $display("FAIL rst_rd_req: got %b want 0", mem_rd_req); end
      n_cmp++; if (mem_wr_req !== 1'b0) begin n_bad++; $display("FAIL rst_wr_req: got %b want 0", mem_wr_req); end
      n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
      n_cmp++; if (mem_wr_data !== '0) begin n_bad++; $display("FAIL rst_wr_data: got %h want 0", mem_wr_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_partial();
      int lat, rd_n, wr_n, stops, w0;
      logic e;
      logic [W-1:0] exp;
      w0 = wr_cnt;
      do_op(6'd19, 12'h123, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b0, 1, 9, 0, 4, 5);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL p23_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (wr_addr_last !== 12'h123) begin n_bad++; $display("FAIL p23_addr: got %h want 123", wr_addr_last); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL p23_latency: got %0d want 3", lat); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL p23_err: got %b want 0", e); end
      n_cmp++; if (rd_n !== 1) begin n_bad++; $display("FAIL p23_rd_cycles: got %0d want 1", rd_n); end
      n_cmp++; if (wr_n !== 1) begin n_bad++; $display("FAIL p23_wr_cycles: got %0d want 1", wr_n); end
      n_cmp++; if (stops !== 1) begin n_bad++; $display("FAIL p23_stops: got %0d want 1", stops); end
      n_cmp++; if (wr_cnt !== w0 + 1) begin n_bad++; $display("FAIL p23_writes: got %0d want %0d", wr_cnt, w0 + 1); end
   endtask

   task automatic test_edges();
      int lat, rd_n, wr_n, stops;
      logic e;
      logic [W-1:0] exp;
      do_op(6'd1, 12'h001, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b1, 0, 2, 3, 4, 5);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL f01_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL f01_latency: got %0d want 3", lat); end
      do_op(6'd45, 12'h045, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b0, 1, 2, 3, 4, 0);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL f55_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL f55_err: got %b want 0", e); end
      do_op(6'd0, 12'h000, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b1, 1, 2, 3, 4, 5);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL f00_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL f00_latency: got %0d want 3", lat); end
      do_op(6'd13, 12'h013, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b0, 6, 7, 8, 9, 0);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL f15_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (rd_n !== 1) begin n_bad++; $display("FAIL f15_rd_cycles: got %0d want 1", rd_n); end
   endtask

   task automatic test_full_word();
      int lat, rd_n, wr_n, stops;
      logic e;
      logic [W-1:0] exp;
      do_op(6'd5, 12'h555, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b1, 6, 7, 8, 9, 0);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL full_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL full_latency: got %0d want 2", lat); end
      n_cmp++; if (rd_n !== 0) begin n_bad++; $display("FAIL full_rd_cycles: got %0d want 0", rd_n); end
      n_cmp++; if (wr_n !== 1) begin n_bad++; $display("FAIL full_wr_cycles: got %0d want 1", wr_n); end
      n_cmp++; if (wr_addr_last !== 12'h555) begin n_bad++; $display("FAIL full_addr: got %h want 555", wr_addr_last); end
   endtask

   task automatic test_illegal();
      int lat, rd_n, wr_n, stops, w0;
      logic e;
      logic [FIELD_W-1:0] specs [2];
      specs[0] = 6'd26;
      specs[1] = 6'd6;
      for (int i = 0; i < 2; i++) begin
         w0 = wr_cnt;
         do_op(specs[i], 12'h777, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
         n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ill%0d_latency: got %0d want 1", specs[i], lat); end
         n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL ill%0d_err: got %b want 1", specs[i], e); end
         n_cmp++; if (rd_n + wr_n !== 0) begin n_bad++; $display("FAIL ill%0d_requests: got %0d want 0", specs[i], rd_n + wr_n); end
         n_cmp++; if (wr_cnt !== w0) begin n_bad++; $display("FAIL ill%0d_writes: got %0d want %0d", specs[i], wr_cnt, w0); end
      end
   endtask

   task automatic test_wait_states();
      int lat, rd_n, wr_n, stops, w0;
      logic e;
      logic [W-1:0] exp;
      rd_delay = 4;
      wr_delay = 2;
      w0 = wr_cnt;
      do_op(6'd19, 12'h2A5, reg_word, 1'b1, lat, rd_n, wr_n, stops, e);
      exp = word(1'b0, 1, 9, 0, 4, 5);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL wait_latency: got %0d want 9", lat); end
      n_cmp++; if (rd_n !== 5) begin n_bad++; $display("FAIL wait_rd_cycles: got %0d want 5", rd_n); end
      n_cmp++; if (wr_n !== 3) begin n_bad++; $display("FAIL wait_wr_cycles: got %0d want 3", wr_n); end
      n_cmp++; if (stops !== 1) begin n_bad++; $display("FAIL wait_stops: got %0d want 1", stops); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wait_err: got %b want 0", e); end
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL wait_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (wr_addr_last !== 12'h2A5) begin n_bad++; $display("FAIL wait_addr: got %h want 2a5", wr_addr_last); end
      n_cmp++; if (wr_cnt !== w0 + 1) begin n_bad++; $display("FAIL wait_writes: got %0d want %0d", wr_cnt, w0 + 1); end
      rd_delay = 0;
      wr_delay = 0;
   endtask

   task automatic test_reset_in_write();
      int lat, rd_n, wr_n, stops, w0;
      logic e;
      logic [W-1:0] exp;
      wr_delay = 5;
      @(negedge clk);
      field = 6'd19;
      addr  = 12'h0F0;
      in_v  = reg_word;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++; if (mem_wr_req !== 1'b1) begin n_bad++; $display("FAIL rw_in_write: got %b want 1", mem_wr_req); end
      w0 = wr_cnt;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (mem_wr_req !== 1'b0) begin n_bad++; $display("FAIL rw_wr_req_drop: got %b want 0", mem_wr_req); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rw_busy_drop: got %b want 0", busy); end
      n_cmp++; if (mem_wr_data !== '0) begin n_bad++; $display("FAIL rw_wr_data_clear: got %h want 0", mem_wr_data); end
      @(negedge clk);
      n_cmp++; if (wr_cnt !== w0) begin n_bad++; $display("FAIL rw_no_write: got %0d want %0d", wr_cnt, w0); end
      rst = 1'b0;
      wr_delay = 0;
      do_op(6'd45, 12'h0F1, reg_word, 1'b0, lat, rd_n, wr_n, stops, e);
      exp = word(1'b0, 1, 2, 3, 4, 0);
      n_cmp++; if (wr_last !== exp) begin n_bad++; $display("FAIL rw_after_data: got %h want %h", wr_last, exp); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rw_after_latency: got %0d want 3", lat); end
      n_cmp++; if (wr_cnt !== w0 + 1) begin n_bad++; $display("FAIL rw_after_writes: got %0d want %0d", wr_cnt, w0 + 1); end
   endtask

   initial begin
      mem_word    = word(1'b0, 1, 2, 3, 4, 5);
      reg_word    = word(1'b1, 6, 7, 8, 9, 0);
      mem_rd_data = mem_word;
      start       = 1'b0;
      field       = '0;
      addr        = '0;
      in_v        = '0;
      rst         = 1'b1;

      test_reset();
      test_partial();
      test_edges();
      test_full_word();
      test_illegal();
      test_wait_states();
      test_reset_in_write();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
